usb_hid_report_queue: RTL and testbench

Parametrised register front-end for the USB HID host core.
- Captures every keyboard or mouse report into a DEPTH-entry FIFO, so software no longer loses reports between polls.
- Exposes a pop-on-read data register, a status register and a control register.
- Provides sticky error and overflow flags, keyboard duplicate suppression, and a level interrupt.
- Sits between usb_hid_host and the CPU bus bridge, entirely in the usb_clk domain.

---
 rtl/usb_hid_pkg.sv | 42 ++++
 rtl/usb_hid_report_queue_if.sv | 28 ++
 rtl/usb_hid_sync_fifo.sv | 63 ++++++
 rtl/usb_hid_report_queue.sv | 179 +++++++++++++++++
 tb/tb_usb_hid_report_queue.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_hid_pkg.sv
// usb_hid_pkg
// Shared types and constants for the USB HID report queue.
//   - hid_typ_e   : report type codes coming from usb_hid_host
//   - reg_addr_e  : register map of the CPU-facing front-end
//   - entry_t     : one queued report, {etype, payload} plus an optional
//                   16-bit timestamp when USB_HID_TIMESTAMP_EN is defined
//   - EMPTY_READ / RESET_RDATA : marker values seen on rdata
// Optional feature macro: USB_HID_TIMESTAMP_EN
package usb_hid_pkg;

    typedef enum logic [1:0] {
        TYP_NONE  = 2'd0,
        TYP_KBD   = 2'd1,
        TYP_MOUSE = 2'd2,
        TYP_GAME  = 2'd3
    } hid_typ_e;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_MODS   = 2'd2,
        REG_CTRL   = 2'd3
    } reg_addr_e;

    localparam logic [31:0] EMPTY_READ  = 32'hDEADBEEF;
    localparam logic [31:0] RESET_RDATA = 32'hDEADBEAF;

    localparam int PAYLOAD_W = 32;
    localparam int ETYPE_W   = 2;
    localparam int TS_W      = 16;

    typedef struct packed {
`ifdef USB_HID_TIMESTAMP_EN
        logic [TS_W-1:0]      ts;
`endif
        logic [ETYPE_W-1:0]   etype;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/usb_hid_report_queue_if.sv
// usb_hid_report_queue_if
// CPU register bus between the bus bridge (master) and the HID report
// queue (slave).
//   rd_en, wr_en : one-cycle read / write strobes
//   addr         : register select (ADDR_W bits)
//   wdata        : write data
//   rdata        : registered read data
//   irq          : level interrupt towards the CPU
interface usb_hid_report_queue_if #(
    parameter int ADDR_W = 2
);
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              irq;

    modport master (
        output rd_en, wr_en, addr, wdata,
        input  rdata, irq
    );

    modport slave (
        input  rd_en, wr_en, addr, wdata,
        output rdata, irq
    );
endinterface

// File: rtl/usb_hid_sync_fifo.sv
// usb_hid_sync_fifo
// Single-clock FIFO with flush. A push into a full FIFO is accepted only
// when a pop happens on the same edge; otherwise it is dropped and the
// caller decides what to flag. Flush wins over push and pop.
//   usb_clk, reset (async, active-low)
//   push, pop, flush, din  : control / write data
//   dout                   : head entry (valid while !empty)
//   count, full, empty     : occupancy
module usb_hid_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             usb_clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge usb_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only slots below count are ever read.
    always_ff @(posedge usb_clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/usb_hid_report_queue.sv
// usb_hid_report_queue
// Register front-end for usb_hid_host: queues keyboard/mouse reports in a
// DEPTH-entry FIFO, exposes pop-on-read DATA, STATUS, MODS and CTRL
// registers, sticky error/overflow flags and a level interrupt.
//   usb_clk, reset (async, active-low)
//   bus      : CPU register bus (slave modport)
//   hid_*    : report type, report pulse, connection error level
//   key_*, mouse_* : report fields
// Optional feature macro: USB_HID_TIMESTAMP_EN (per-entry 16-bit
// timestamp, readable at CTRL without popping).
module usb_hid_report_queue
    import usb_hid_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 2,
    parameter int KEY_DEDUP = 1
) (
    input  logic                          usb_clk,
    input  logic                          reset,
    usb_hid_report_queue_if.slave         bus,
    input  logic [1:0]                    hid_typ,
    input  logic                          hid_report,
    input  logic                          hid_conerr,
    input  logic [7:0]                    key_modifiers,
    input  logic [7:0]                    key1,
    input  logic [7:0]                    key2,
    input  logic [7:0]                    key3,
    input  logic [7:0]                    key4,
    input  logic [7:0]                    mouse_btn,
    input  logic [7:0]                    mouse_dx,
    input  logic [7:0]                    mouse_dy
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [39:0]   last_key;
    logic [7:0]    last_mods;
    logic [1:0]    prev_typ;
    logic          overflow;
    logic          err_sticky;
    logic          irq_en;
    logic          pend_valid;
    entry_t        pend_entry;
    entry_t        new_entry;
    entry_t        head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   ctrl_read;

    logic [39:0] key_now;
    logic        kbd_rep;
    logic        mouse_rep;
    logic        kbd_new;
    logic        capture;
    logic        ctrl_wr;
    logic        pop_rd;
    logic        disconnect;
    logic        flush;
    logic        fifo_push;
    logic        unused_wdata;

    assign key_now    = {key_modifiers, key1, key2, key3, key4};
    assign kbd_rep    = hid_report && (hid_typ == TYP_KBD);
    assign mouse_rep  = hid_report && (hid_typ == TYP_MOUSE);
    assign kbd_new    = (KEY_DEDUP == 0) || (key_now != last_key);
    assign capture    = (kbd_rep && kbd_new) || mouse_rep;
    assign ctrl_wr    = bus.wr_en && (bus.addr == ADDR_W'(REG_CTRL));
    assign pop_rd     = bus.rd_en && (bus.addr == ADDR_W'(REG_DATA));
    assign disconnect = (prev_typ != TYP_NONE) && (hid_typ == TYP_NONE);
    assign flush      = disconnect || (ctrl_wr && bus.wdata[0]);
    assign fifo_push  = pend_valid && !flush;
    assign bus.irq    = irq_en && !fifo_empty;
    assign unused_wdata = &{1'b0, bus.wdata[31:3]};

`ifdef USB_HID_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    // Free-running timestamp, wraps at 16 bits.
    always_ff @(posedge usb_clk or negedge reset) begin
        if (!reset) ts_cnt <= '0;
        else        ts_cnt <= ts_cnt + TS_W'(1);
    end

    assign ctrl_read = fifo_empty ? 32'h0 : {16'h0, head.ts};
`else
    assign ctrl_read = 32'h0;
`endif

    // Build the queue entry from whichever report type is active.
    always_comb begin
        new_entry       = '0;
        new_entry.etype = hid_typ;
        if (hid_typ == TYP_KBD) new_entry.payload = {key1, key2, key3, key4};
        else                    new_entry.payload = {8'h00, mouse_btn, mouse_dx, mouse_dy};
`ifdef USB_HID_TIMESTAMP_EN
        new_entry.ts = ts_cnt;
`endif
    end

    // One-stage capture register: a report at edge N lands in the FIFO at
    // edge N+1. A flush kills both the staged entry and a new capture.
    always_ff @(posedge usb_clk or negedge reset) begin
        if (!reset) begin
            pend_valid <= 1'b0;
            pend_entry <= '0;
        end else begin
            pend_valid <= capture && !flush;
            if (capture) pend_entry <= new_entry;
        end
    end

    usb_hid_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .usb_clk (usb_clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (pop_rd),
        .flush   (flush),
        .din     (pend_entry),
        .dout    (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Keyboard history for duplicate suppression; updated on every keyboard
    // report whether or not it was queued, forgotten on disconnect.
    always_ff @(posedge usb_clk or negedge reset) begin
        if (!reset) begin
            last_key  <= '0;
            last_mods <= '0;
            prev_typ  <= TYP_NONE;
        end else begin
            prev_typ <= hid_typ;
            if (disconnect) begin
                last_key  <= '0;
                last_mods <= '0;
            end else if (kbd_rep) begin
                last_key  <= key_now;
                last_mods <= key_modifiers;
            end
        end
    end

    // Sticky flags: a setting event on the same edge as a clear wins.
    always_ff @(posedge usb_clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            err_sticky <= 1'b0;
            irq_en     <= 1'b0;
        end else begin
            if (fifo_push && fifo_full && !pop_rd) overflow <= 1'b1;
            else if (ctrl_wr && bus.wdata[1])      overflow <= 1'b0;
            if (hid_conerr)                        err_sticky <= 1'b1;
            else if (ctrl_wr && bus.wdata[1])      err_sticky <= 1'b0;
            if (ctrl_wr)                           irq_en <= bus.wdata[2];
        end
    end

    // Registered read mux; a read is honoured even alongside a write.
    always_ff @(posedge usb_clk or negedge reset) begin
        if (!reset) begin
            bus.rdata <= RESET_RDATA;
        end else if (bus.rd_en) begin
            case (bus.addr)
                ADDR_W'(REG_DATA):   bus.rdata <= fifo_empty ? EMPTY_READ : head.payload;
                ADDR_W'(REG_STATUS): bus.rdata <= {16'h0, 8'(fifo_count),
                                                   (fifo_empty ? 2'b00 : head.etype),
                                                   prev_typ, err_sticky, overflow,
                                                   fifo_full, fifo_empty};
                ADDR_W'(REG_MODS):   bus.rdata <= {8'h0, last_mods, 16'h0};
                ADDR_W'(REG_CTRL):   bus.rdata <= ctrl_read;
                default:             bus.rdata <= 32'h0;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_hid_report_queue.sv
// tb_usb_hid_report_queue
// Self-checking bench for usb_hid_report_queue (DEPTH=8, KEY_DEDUP=1).
// Queued payloads are tracked in a scoreboard queue and compared as they
// are popped through the DATA register.
module tb_usb_hid_report_queue;
    import usb_hid_pkg::*;

    localparam int DEPTH = 8;

    logic       usb_clk = 1'b0;
    logic       reset   = 1'b0;
    logic [1:0] hid_typ;
    logic       hid_report;
    logic       hid_conerr;
    logic [7:0] key_modifiers, key1, key2, key3, key4;
    logic [7:0] mouse_btn, mouse_dx, mouse_dy;

    int vectors_applied = 0;
    int miscompares     = 0;

    logic [31:0] sb [$];
    logic [7:0]  model_mods;

    typedef struct {
        logic [1:0]  typ;
        logic [7:0]  mods, k1, k2, k3, k4, btn, dx, dy;
        logic        exp_push;
        logic [31:0] exp_payload;
    } vec_t;

    vec_t vecs [8];

    always #5 usb_clk = ~usb_clk;

    usb_hid_report_queue_if #(.ADDR_W(2)) bus ();

    usb_hid_report_queue #(
        .DEPTH     (DEPTH),
        .ADDR_W    (2),
        .KEY_DEDUP (1)
    ) dut (
        .usb_clk       (usb_clk),
        .reset         (reset),
        .bus           (bus),
        .hid_typ       (hid_typ),
        .hid_report    (hid_report),
        .hid_conerr    (hid_conerr),
        .key_modifiers (key_modifiers),
        .key1          (key1),
        .key2          (key2),
        .key3          (key3),
        .key4          (key4),
        .mouse_btn     (mouse_btn),
        .mouse_dx      (mouse_dx),
        .mouse_dy      (mouse_dy)
    );

    task automatic tick();
        @(posedge usb_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic regRead(input logic [1:0] a, output logic [31:0] d);
        bus.addr  = a;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        d = bus.rdata;
    endtask

    task automatic regWrite(input logic [1:0] a, input logic [31:0] data);
        bus.addr  = a;
        bus.wdata = data;
        bus.wr_en = 1'b1;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic setFields(input vec_t v);
        hid_typ       = v.typ;
        key_modifiers = v.mods;
        key1 = v.k1; key2 = v.k2; key3 = v.k3; key4 = v.k4;
        mouse_btn = v.btn; mouse_dx = v.dx; mouse_dy = v.dy;
    endtask

    // Drive one report pulse, then one idle cycle so the entry is counted.
    task automatic applyStimulus(input vec_t v);
        setFields(v);
        hid_report = 1'b1;
        if (v.exp_push) sb.push_back(v.exp_payload);
        if (v.typ == 2'd1) model_mods = v.mods;
        tick();
        hid_report = 1'b0;
        tick();
    endtask

    function automatic vec_t mouseVec(input logic [7:0] btn, dx, dy, input logic push);
        vec_t v;
        v = '{2'd2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, btn, dx, dy, push, {8'h00, btn, dx, dy}};
        return v;
    endfunction

    function automatic vec_t kbdVec(input logic [7:0] mods, k1, k2, k3, k4, input logic push);
        vec_t v;
        v = '{2'd1, mods, k1, k2, k3, k4, 8'h00, 8'h00, 8'h00, push, {k1, k2, k3, k4}};
        return v;
    endfunction

    task automatic popCheck(input string name);
        logic [31:0] d;
        logic [31:0] exp;
        regRead(2'd0, d);
        if (sb.size() > 0) exp = sb.pop_front();
        else               exp = EMPTY_READ;
        checkOutput(name, d, exp);
    endtask

    task automatic checkCount(input string name);
        logic [31:0] d;
        regRead(2'd1, d);
        checkOutput(name, {24'h0, d[15:8]}, 32'(sb.size()));
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] exp;

        hid_typ = 2'd0; hid_report = 1'b0; hid_conerr = 1'b0;
        key_modifiers = 8'h00; key1 = 8'h00; key2 = 8'h00; key3 = 8'h00; key4 = 8'h00;
        mouse_btn = 8'h00; mouse_dx = 8'h00; mouse_dy = 8'h00;
        bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.addr = 2'd0; bus.wdata = 32'h0;
        model_mods = 8'h00;

        vecs[0] = kbdVec(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 1'b1);
        vecs[1] = kbdVec(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[2] = kbdVec(8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 1'b1);
        vecs[3] = kbdVec(8'h02, 8'h05, 8'h00, 8'h00, 8'h00, 1'b1);
        vecs[4] = '{2'd3, 8'h55, 8'h66, 8'h00, 8'h00, 8'h00, 8'h07, 8'h08, 8'h09, 1'b0, 32'h0};
        vecs[5] = mouseVec(8'h02, 8'hFF, 8'h01, 1'b1);
        vecs[6] = kbdVec(8'h02, 8'h05, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[7] = kbdVec(8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1);

        // Reset state
        repeat (3) tick();
        reset = 1'b1;
        checkOutput("reset_rdata", bus.rdata, RESET_RDATA);
        checkOutput("reset_irq", {31'h0, bus.irq}, 32'h0);
        popCheck("empty_pop_after_reset");
        regRead(2'd1, d);
        checkOutput("reset_status", d, 32'h0000_0001);
        regRead(2'd3, d);
        checkOutput("ctrl_read_empty", d, 32'h0);

        // Single mouse report with interrupt enable
        applyStimulus(mouseVec(8'h01, 8'h05, 8'hFB, 1'b1));
        regWrite(2'd3, 32'h4);
        checkOutput("irq_on", {31'h0, bus.irq}, 32'h1);
        regRead(2'd1, d);
        checkOutput("status_one_mouse", d, 32'h0000_01A0);
        popCheck("mouse_payload");
        checkOutput("irq_off_after_pop", {31'h0, bus.irq}, 32'h0);
        regRead(2'd1, d);
        checkOutput("status_empty_again", d, 32'h0000_0021);

        // Table of reports: dedup, type filtering, modifier tracking
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            checkCount($sformatf("table_count_%0d", i));
            regRead(2'd2, d);
            checkOutput($sformatf("table_mods_%0d", i), d, {8'h0, model_mods, 16'h0});
        end
        while (sb.size() > 0) popCheck("table_drain");
        popCheck("table_drain_empty");

        // Overflow: nine pushes into an eight-entry FIFO
        for (int i = 0; i < 9; i++)
            applyStimulus(mouseVec(8'h00, 8'h00, 8'(i), i < DEPTH));
        regRead(2'd1, d);
        checkOutput("status_full_ovf", d, 32'h0000_08A6);
        for (int i = 0; i < DEPTH; i++) popCheck($sformatf("ovf_pop_%0d", i));
        regRead(2'd1, d);
        checkOutput("status_ovf_sticky", d, 32'h0000_0025);
        regWrite(2'd3, 32'h6);
        regRead(2'd1, d);
        checkOutput("status_ovf_cleared", d, 32'h0000_0021);

        // Full FIFO: report and pop on the same edge
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(mouseVec(8'h01, 8'h10, 8'(8'h10 + i), 1'b1));
        setFields(mouseVec(8'h01, 8'h20, 8'h99, 1'b1));
        hid_report = 1'b1; bus.addr = 2'd0; bus.rd_en = 1'b1;
        tick();
        hid_report = 1'b0; bus.rd_en = 1'b0;
        exp = sb.pop_front();
        checkOutput("full_push_pop_data", bus.rdata, exp);
        sb.push_back(32'h0001_2099);
        tick();
        regRead(2'd1, d);
        checkOutput("full_push_pop_status", d, 32'h0000_08A2);
        while (sb.size() > 0) popCheck("full_drain");

        // Empty FIFO: report and pop on the same edge
        setFields(mouseVec(8'h03, 8'h04, 8'h05, 1'b1));
        hid_report = 1'b1; bus.addr = 2'd0; bus.rd_en = 1'b1;
        tick();
        hid_report = 1'b0; bus.rd_en = 1'b0;
        checkOutput("empty_push_pop_data", bus.rdata, EMPTY_READ);
        sb.push_back(32'h0003_0405);
        tick();
        checkCount("empty_push_pop_count");
        popCheck("empty_push_pop_stored");

        // Simultaneous read and write
        applyStimulus(mouseVec(8'h00, 8'h11, 8'h22, 1'b1));
        checkOutput("irq_before_rdwr", {31'h0, bus.irq}, 32'h1);
        bus.addr = 2'd0; bus.wdata = 32'hFFFF_FFFF; bus.rd_en = 1'b1; bus.wr_en = 1'b1;
        tick();
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;
        exp = sb.pop_front();
        checkOutput("rdwr_data_pop", bus.rdata, exp);
        applyStimulus(mouseVec(8'h00, 8'h33, 8'h44, 1'b1));
        checkOutput("irq_en_kept", {31'h0, bus.irq}, 32'h1);
        bus.addr = 2'd3; bus.wdata = 32'h0; bus.rd_en = 1'b1; bus.wr_en = 1'b1;
        tick();
        bus.rd_en = 1'b0; bus.wr_en = 1'b0;
`ifndef USB_HID_TIMESTAMP_EN
        checkOutput("rdwr_ctrl_read", bus.rdata, 32'h0);
`endif
        checkOutput("rdwr_ctrl_write_irq", {31'h0, bus.irq}, 32'h0);
        while (sb.size() > 0) popCheck("rdwr_drain");
        regWrite(2'd3, 32'h4);

        // Disconnect flushes the queue and forgets keyboard history
        applyStimulus(kbdVec(8'h11, 8'h21, 8'h00, 8'h00, 8'h00, 1'b1));
        applyStimulus(kbdVec(8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 1'b1));
        applyStimulus(kbdVec(8'h11, 8'h23, 8'h00, 8'h00, 8'h00, 1'b1));
        checkCount("disc_count_before");
        regRead(2'd2, d);
        checkOutput("disc_mods_before", d, 32'h0011_0000);
        hid_typ = 2'd0;
        tick();
        sb.delete();
        model_mods = 8'h00;
        regRead(2'd1, d);
        checkOutput("disc_status", d, 32'h0000_0001);
        checkOutput("disc_irq", {31'h0, bus.irq}, 32'h0);
        regRead(2'd2, d);
        checkOutput("disc_mods_cleared", d, 32'h0);
        applyStimulus(kbdVec(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0));
        checkCount("disc_zero_report_deduped");
        applyStimulus(kbdVec(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 1'b1));
        checkCount("disc_new_report");

        // Connection error sticky flag
        hid_conerr = 1'b1;
        tick();
        hid_conerr = 1'b0;
        regRead(2'd1, d);
        checkOutput("err_set", {31'h0, d[3]}, 32'h1);
        regRead(2'd1, d);
        checkOutput("err_holds", {31'h0, d[3]}, 32'h1);
        hid_conerr = 1'b1;
        regWrite(2'd3, 32'h6);
        hid_conerr = 1'b0;
        regRead(2'd1, d);
        checkOutput("err_clear_vs_set", {31'h0, d[3]}, 32'h1);
        regWrite(2'd3, 32'h6);
        regRead(2'd1, d);
        checkOutput("err_cleared", {31'h0, d[3]}, 32'h0);

        // Control flush, including a report on the flush edge
        applyStimulus(mouseVec(8'h03, 8'h01, 8'h02, 1'b1));
        checkCount("flush_count_before");
        regWrite(2'd3, 32'h5);
        sb.delete();
        regRead(2'd1, d);
        checkOutput("flush_status", d, 32'h0000_0021);
        setFields(mouseVec(8'h07, 8'h07, 8'h07, 1'b0));
        hid_report = 1'b1; bus.addr = 2'd3; bus.wdata = 32'h5; bus.wr_en = 1'b1;
        tick();
        hid_report = 1'b0; bus.wr_en = 1'b0;
        tick();
        regRead(2'd1, d);
        checkOutput("flush_beats_push", d, 32'h0000_0021);

        // Reset in the middle of operation
        applyStimulus(mouseVec(8'h01, 8'h01, 8'h01, 1'b1));
        applyStimulus(mouseVec(8'h02, 8'h02, 8'h02, 1'b1));
        checkOutput("irq_before_reset", {31'h0, bus.irq}, 32'h1);
        reset = 1'b0;
        #1;
        checkOutput("midreset_rdata", bus.rdata, RESET_RDATA);
        checkOutput("midreset_irq", {31'h0, bus.irq}, 32'h0);
        tick();
        reset = 1'b1;
        sb.delete();
        regRead(2'd1, d);
        checkOutput("midreset_status", d, 32'h0000_0001);
        popCheck("midreset_pop_empty");

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end
endmodule
